fetch_word_addr_gen: RTL
========================

// Module: fetch_word_addr_gen
// PURPOSE
// - Instruction-fetch PC generator: holds the byte-addressed PC and emits the word index (PC >> 2) to the inst SRAM.
// - Performs the inverse of the branch-offset left-shift path.
// - Sits between the branch/exception redirect logic and the inst SRAM port.
// - Detects misaligned redirect targets and raises AdEL instead of fetching.
// PARAMETERS
// - RESET_PC  32'hBFC0_0000  byte PC loaded on reset
// PORTS
// - clk             in   1   system clock, rising edge
// - resetn          in   1   asynchronous, active-low reset
// - stall_i         in   1   pipeline stall; hold PC, suppress fetch
// - branch_valid_i  in   1   taken branch/jump redirect this cycle
// - branch_target_i in   32  byte target of branch/jump
// - exc_valid_i     in   1   exception/ERET redirect (flush)
// - exc_target_i    in   32  byte target of exception redirect; bits [1:0] ignored
// - inst_sram_en    out  1   fetch enable to inst SRAM
// - inst_word_addr  out  30  word index = pc_o[31:2]
// - pc_o            out  32  current fetch byte PC, to decode stage
// - adel_o          out  1   misaligned fetch fault pending
// - badvaddr_o      out  32  faulting byte address, valid while adel_o=1
// BEHAVIOUR
// - Reset: asynchronous, active-low (resetn=0).
//   - Values: pc_o=RESET_PC, state=IDLE, inst_sram_en=0, adel_o=0, badvaddr_o=0.
// - States: IDLE, RUN, FAULT. IDLE lasts exactly one cycle after resetn rises, then goes to RUN.
//   - inst_sram_en=0 in IDLE.
// - RUN: inst_sram_en = ~stall_i; inst_word_addr is combinational from pc_o.
// - Next-PC priority, registered and applied at the next edge:
//   1. exc_valid_i -> {exc_target_i[31:2],2'b00}; state RUN (from any non-IDLE state).
//   2. branch_valid_i with target[1:0]==0 -> branch_target_i.
//   3. branch_valid_i with target[1:0]!=0 -> pc unchanged; badvaddr_o<=target; adel_o<=1; state FAULT.
//   4. stall_i -> hold.
//   5. otherwise -> pc_o+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
// - Redirect vs. stall: exc_valid_i and branch_valid_i override stall_i.
//   - Redirects are one-shot pulses and must not be lost.
// - FAULT:
//   - inst_sram_en=0; adel_o=1; badvaddr_o held; pc_o held; branch_valid_i and stall_i ignored.
//   - Leaves only on exc_valid_i, which clears adel_o and loads the exception target.
// - IDLE: redirect inputs ignored.
// - Latency: a redirect accepted at edge N appears on inst_word_addr after edge N; fetch at the new word in that cycle.
// - Delay slots are handled upstream; this block has no notion of them.
// - resetn asserted mid-FAULT or mid-RUN returns all state to reset values immediately, without waiting for clk.
// STRUCTURE
// - Shared package: state encoding (IDLE=2'd0, RUN=2'd1, FAULT=2'd2), RESET_PC default, EXC_VEC=32'hBFC0_0380.
// - Sub-module: pc_next_mux.
//   - Combinational priority mux: inputs are redirects, stall and pc; outputs are next_pc and misalign flag.
//   - The FSM and registers stay in the top.
// TESTING
// - Reset release: resetn 0->1.
//   - Cycle 0: en=0, word=0x2FF0_0000.
//   - Cycle 1: en=1, word=0x2FF0_0000.
//   - Cycle 2: pc=0xBFC0_0004.
// - Aligned branch to 0x8000_1000: next cycle pc=0x8000_1000, word=0x2000_0400, en=1.
// - Misaligned branch to 0x8000_1002:
//   - Next cycle adel=1, badvaddr=0x8000_1002, en=0, pc unchanged.
//   - Then exc redirect to 0xBFC0_0380 -> adel=0, pc=0xBFC0_0380, RUN.
// - Simultaneous exc(0xBFC0_0380) + branch(0x8000_0000) + stall: pc=0xBFC0_0380 next cycle.
// - stall_i high 3 cycles: pc and word constant, en=0; pc+4 resumes after release.
// - Wrap and reset:
//   - Branch to 0xFFFF_FFFC, then free-run -> pc=0x0000_0000.
//   - resetn pulse mid-FAULT -> pc=RESET_PC, adel=0 asynchronously.

Source files
------------

// File: rtl/fetch_word_addr_gen_pkg.sv
// Shared definitions for the instruction-fetch PC generator.
// Holds the FSM state encoding, the default reset PC, the exception vector
// and small address helpers used by the top and the next-PC mux.
package fetch_word_addr_gen_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE  = 2'd0;
    localparam fetch_state_t ST_RUN   = 2'd1;
    localparam fetch_state_t ST_FAULT = 2'd2;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VEC          = 32'hBFC0_0380;

    // Force a byte address onto its word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // True when a byte address does not sit on a word boundary.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_word_addr_gen_if.sv
// Bus between the redirect logic / decode stage and the fetch PC generator.
// slave  : the PC generator (consumes redirects/stall, drives the fetch port)
// master : the surrounding pipeline / testbench
interface fetch_word_addr_gen_if;

    logic        stall_i;
    logic        branch_valid_i;
    logic [31:0] branch_target_i;
    logic        exc_valid_i;
    logic [31:0] exc_target_i;
    logic        inst_sram_en;
    logic [29:0] inst_word_addr;
    logic [31:0] pc_o;
    logic        adel_o;
    logic [31:0] badvaddr_o;

    modport slave (
        input  stall_i, branch_valid_i, branch_target_i, exc_valid_i, exc_target_i,
        output inst_sram_en, inst_word_addr, pc_o, adel_o, badvaddr_o
    );

    modport master (
        output stall_i, branch_valid_i, branch_target_i, exc_valid_i, exc_target_i,
        input  inst_sram_en, inst_word_addr, pc_o, adel_o, badvaddr_o
    );

endinterface

// File: rtl/fetch_word_addr_gen_pc_next_mux.sv
// Combinational next-PC priority mux.
// Ports:
//   exc_valid_i / exc_target_i       exception redirect (highest priority)
//   branch_valid_i / branch_target_i branch redirect
//   stall_i                          hold current PC
//   pc_i                             current byte PC
//   next_pc_o                        selected next byte PC
//   misalign_o                       branch target not word aligned (PC held)
module pc_next_mux
    import fetch_word_addr_gen_pkg::*;
(
    input  logic        exc_valid_i,
    input  logic [31:0] exc_target_i,
    input  logic        branch_valid_i,
    input  logic [31:0] branch_target_i,
    input  logic        stall_i,
    input  logic [31:0] pc_i,
    output logic [31:0] next_pc_o,
    output logic        misalign_o
);

    // Priority: exception > aligned branch > misaligned branch (hold) > stall > +4
    always_comb begin
        next_pc_o  = pc_i;
        misalign_o = 1'b0;
        if (exc_valid_i) begin
            next_pc_o = word_align(exc_target_i);
        end else if (branch_valid_i) begin
            if (is_misaligned(branch_target_i)) begin
                misalign_o = 1'b1;
            end else begin
                next_pc_o = branch_target_i;
            end
        end else if (stall_i) begin
            next_pc_o = pc_i;
        end else begin
            // 32-bit add wraps 32'hFFFF_FFFC to zero
            next_pc_o = pc_i + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_word_addr_gen.sv
// Instruction-fetch PC generator.
// Holds the byte PC, presents the word index to the inst SRAM, applies
// branch/exception redirects and traps misaligned branch targets as AdEL.
// Ports:
//   clk, resetn  clock and asynchronous active-low reset
//   bus (slave)  stall/redirect inputs, SRAM fetch port, pc_o, adel_o, badvaddr_o
module fetch_word_addr_gen
    import fetch_word_addr_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetn,
    fetch_word_addr_gen_if.slave  bus
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         adel_q, adel_d;
    logic [31:0]  badvaddr_q, badvaddr_d;
    logic [31:0]  next_pc_s;
    logic         misalign_s;

    pc_next_mux u_pc_next_mux (
        .exc_valid_i     (bus.exc_valid_i),
        .exc_target_i    (bus.exc_target_i),
        .branch_valid_i  (bus.branch_valid_i),
        .branch_target_i (bus.branch_target_i),
        .stall_i         (bus.stall_i),
        .pc_i            (pc_q),
        .next_pc_o       (next_pc_s),
        .misalign_o      (misalign_s)
    );

    // FSM and next-state for PC / fault registers
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        adel_d     = adel_q;
        badvaddr_d = badvaddr_q;
        case (state_q)
            ST_IDLE: begin
                // One settling cycle after reset; redirects are ignored here
                state_d = ST_RUN;
            end
            ST_RUN: begin
                pc_d = next_pc_s;
                if (misalign_s) begin
                    adel_d     = 1'b1;
                    badvaddr_d = bus.branch_target_i;
                    state_d    = ST_FAULT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                // Only an exception redirect releases the fault
                if (bus.exc_valid_i) begin
                    pc_d    = word_align(bus.exc_target_i);
                    adel_d  = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                pc_d       = RESET_PC;
                adel_d     = 1'b0;
                badvaddr_d = 32'h0000_0000;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            adel_q     <= 1'b0;
            badvaddr_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            adel_q     <= adel_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    assign bus.inst_sram_en   = (state_q == ST_RUN) & ~bus.stall_i;
    assign bus.inst_word_addr = pc_q[31:2];
    assign bus.pc_o           = pc_q;
    assign bus.adel_o         = adel_q;
    assign bus.badvaddr_o     = badvaddr_q;

endmodule
